vid_ctl_gen: RTL and testbench

//  Pixel-rate video control generator directly upstream of VideoGen.
//  - Samples H/V counter values and the pixel colour; emits n_CC, n_LL, n_TR/n_TG/n_TB, SYNC, BURST and n_PICTURE.
//  - Output timing comes from programmable windows and a two-stage pixel pipeline.
//  - Runs on the master clock CLK; pixel ticks come from rising edges of the sampled PCLK level.

---
 rtl/vid_ctl_gen_pkg.sv | 41 ++++
 rtl/vid_ctl_gen_if.sv | 38 +++
 rtl/vid_ctl_gen_hwin.sv | 9 +
 rtl/vid_ctl_gen.sv | 142 ++++++++++++++
 tb/tb_vid_ctl_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vid_ctl_gen_pkg.sv
// Shared constants for the video control generator: window defaults (2C02 and 2C07),
// idle output encodings and the pixel class encoding.
package vid_ctl_gen_pkg;

  localparam logic [8:0] C02_HMAX        = 9'd340;
  localparam logic [8:0] C02_PIC_END     = 9'd256;
  localparam logic [8:0] C02_HSYNC_START = 9'd277;
  localparam logic [8:0] C02_HSYNC_END   = 9'd302;
  localparam logic [8:0] C02_BURST_START = 9'd306;
  localparam logic [8:0] C02_BURST_END   = 9'd321;
  localparam logic [8:0] C02_VPIC_END    = 9'd240;
  localparam logic [8:0] C02_VSYNC_START = 9'd244;
  localparam logic [8:0] C02_VSYNC_END   = 9'd247;

  // PAL part: same horizontal timing, longer frame with vsync further down
  localparam logic [8:0] C07_HMAX        = 9'd340;
  localparam logic [8:0] C07_PIC_END     = 9'd256;
  localparam logic [8:0] C07_HSYNC_START = 9'd277;
  localparam logic [8:0] C07_HSYNC_END   = 9'd302;
  localparam logic [8:0] C07_BURST_START = 9'd306;
  localparam logic [8:0] C07_BURST_END   = 9'd321;
  localparam logic [8:0] C07_VPIC_END    = 9'd239;
  localparam logic [8:0] C07_VSYNC_START = 9'd269;
  localparam logic [8:0] C07_VSYNC_END   = 9'd272;

  localparam logic [3:0] N_CC_IDLE = 4'hF;
  localparam logic [1:0] N_LL_IDLE = 2'b11;
  localparam logic [5:0] COL_BLANK = 6'h0F;

  typedef enum logic [1:0] {
    CLS_SYNC   = 2'd0,
    CLS_BURST  = 2'd1,
    CLS_PIC    = 2'd2,
    CLS_BORDER = 2'd3
  } pix_class_t;

  function automatic logic [5:0] gray_col(input logic [5:0] col, input logic gray);
    return gray ? {col[5:4], 4'h0} : col;
  endfunction

endpackage

// File: rtl/vid_ctl_gen_if.sv
// Pixel-side bundle between the counters/palette and the video control generator.
// GRAY exists only when VID_GRAYSCALE_EN is defined.
interface vid_ctl_gen_if;
  logic       PCLK;
  logic [8:0] H_in;
  logic [8:0] V_in;
  logic [5:0] PAL_in;
  logic [5:0] BG_in;
  logic [2:0] EMPH_in;
`ifdef VID_GRAYSCALE_EN
  logic       GRAY;
`endif
  logic [3:0] n_CC;
  logic [1:0] n_LL;
  logic       n_TR;
  logic       n_TG;
  logic       n_TB;
  logic       SYNC;
  logic       BURST;
  logic       n_PICTURE;
  logic       ODD;

  modport master (
    output PCLK, H_in, V_in, PAL_in, BG_in, EMPH_in,
`ifdef VID_GRAYSCALE_EN
    output GRAY,
`endif
    input  n_CC, n_LL, n_TR, n_TG, n_TB, SYNC, BURST, n_PICTURE, ODD
  );

  modport slave (
    input  PCLK, H_in, V_in, PAL_in, BG_in, EMPH_in,
`ifdef VID_GRAYSCALE_EN
    input  GRAY,
`endif
    output n_CC, n_LL, n_TR, n_TG, n_TB, SYNC, BURST, n_PICTURE, ODD
  );
endinterface

// File: rtl/vid_ctl_gen_hwin.sv
// Half-open window test: in_window = value in [win_start, win_end).
module vid_hwin (
  input  logic [8:0] value,
  input  logic [8:0] win_start,
  input  logic [8:0] win_end,
  output logic       in_window
);
  assign in_window = (value >= win_start) && (value < win_end);
endmodule

// File: rtl/vid_ctl_gen.sv
// Pixel-rate video control generator: two-stage pipeline from H/V/colour samples to
// inverted colour, emphasis, SYNC/BURST/n_PICTURE and field parity. Option: VID_GRAYSCALE_EN.
module vid_ctl_gen
  import vid_ctl_gen_pkg::*;
#(
  parameter logic [8:0] HMAX        = C02_HMAX,
  parameter logic [8:0] PIC_END     = C02_PIC_END,
  parameter logic [8:0] HSYNC_START = C02_HSYNC_START,
  parameter logic [8:0] HSYNC_END   = C02_HSYNC_END,
  parameter logic [8:0] BURST_START = C02_BURST_START,
  parameter logic [8:0] BURST_END   = C02_BURST_END,
  parameter logic [8:0] VPIC_END    = C02_VPIC_END,
  parameter logic [8:0] VSYNC_START = C02_VSYNC_START,
  parameter logic [8:0] VSYNC_END   = C02_VSYNC_END
) (
  input  logic         CLK,
  input  logic         RES,
  vid_ctl_gen_if.slave bus
);

  logic       pclk_d;
  logic       tick;
  logic       vs_w, hs_w, bu_w, hp_w, vp_w;
  pix_class_t cls_d, s1_cls;
  logic [5:0] col_src, col_d, s1_col;
  logic [2:0] s1_emph;
  logic [8:0] v_prev;
  logic       odd;

  logic       sync_d, burst_d, npic_d;
  logic [3:0] ncc_d;
  logic [1:0] nll_d;
  logic [2:0] nt_d;
  logic       sync_q, burst_q, npic_q;
  logic [3:0] ncc_q;
  logic [1:0] nll_q;
  logic [2:0] nt_q;

  assign tick = bus.PCLK & ~pclk_d;

  vid_hwin u_vsync (.value(bus.V_in), .win_start(VSYNC_START), .win_end(VSYNC_END), .in_window(vs_w));
  vid_hwin u_hsync (.value(bus.H_in), .win_start(HSYNC_START), .win_end(HSYNC_END), .in_window(hs_w));
  vid_hwin u_burst (.value(bus.H_in), .win_start(BURST_START), .win_end(BURST_END), .in_window(bu_w));
  vid_hwin u_hpic  (.value(bus.H_in), .win_start('0),          .win_end(PIC_END),   .in_window(hp_w));
  vid_hwin u_vpic  (.value(bus.V_in), .win_start('0),          .win_end(VPIC_END),  .in_window(vp_w));

  // Stage 1 classification; out-of-range H overrides every window and blanks the colour
  always_comb begin
    cls_d   = CLS_BORDER;
    col_src = bus.BG_in;
    if (bus.H_in > HMAX) begin
      cls_d = CLS_BORDER;
    end else if (vs_w || hs_w) begin
      cls_d = CLS_SYNC;
    end else if (bu_w) begin
      cls_d = CLS_BURST;
    end else if (hp_w && vp_w) begin
      cls_d   = CLS_PIC;
      col_src = bus.PAL_in;
    end
`ifdef VID_GRAYSCALE_EN
    col_d = gray_col(col_src, bus.GRAY);
`else
    col_d = col_src;
`endif
    if (bus.H_in > HMAX) col_d = COL_BLANK;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      pclk_d  <= 1'b1;
      s1_cls  <= CLS_BORDER;
      s1_col  <= '0;
      s1_emph <= '0;
      v_prev  <= '0;
      odd     <= 1'b0;
    end else begin
      pclk_d <= bus.PCLK;
      if (tick) begin
        s1_cls  <= cls_d;
        s1_col  <= col_d;
        s1_emph <= bus.EMPH_in;
        v_prev  <= bus.V_in;
        if (bus.V_in == '0 && v_prev != '0) odd <= ~odd;
      end
    end
  end

  always_comb begin
    sync_d  = 1'b0;
    burst_d = 1'b0;
    npic_d  = 1'b1;
    ncc_d   = ~s1_col[3:0];
    nll_d   = ~s1_col[5:4];
    nt_d    = ~s1_emph;
    case (s1_cls)
      CLS_SYNC: begin
        sync_d = 1'b1;
        ncc_d  = N_CC_IDLE;
        nll_d  = N_LL_IDLE;
        nt_d   = '1;
      end
      CLS_BURST: begin
        burst_d = 1'b1;
        ncc_d   = N_CC_IDLE;
        nll_d   = N_LL_IDLE;
        nt_d    = '1;
      end
      CLS_PIC:  npic_d = 1'b0;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      sync_q  <= 1'b0;
      burst_q <= 1'b0;
      npic_q  <= 1'b1;
      ncc_q   <= N_CC_IDLE;
      nll_q   <= N_LL_IDLE;
      nt_q    <= '1;
    end else if (tick) begin
      sync_q  <= sync_d;
      burst_q <= burst_d;
      npic_q  <= npic_d;
      ncc_q   <= ncc_d;
      nll_q   <= nll_d;
      nt_q    <= nt_d;
    end
  end

  assign bus.SYNC      = sync_q;
  assign bus.BURST     = burst_q;
  assign bus.n_PICTURE = npic_q;
  assign bus.n_CC      = ncc_q;
  assign bus.n_LL      = nll_q;
  assign bus.n_TR      = nt_q[0];
  assign bus.n_TG      = nt_q[1];
  assign bus.n_TB      = nt_q[2];
  assign bus.ODD       = odd;

endmodule

// File: tb/tb_vid_ctl_gen.sv
// Directed bench for vid_ctl_gen; outs packs {SYNC,BURST,n_PICTURE,n_CC,n_LL,n_TR,n_TG,n_TB}.
module tb_vid_ctl_gen;
  logic CLK = 1'b0;
  logic RES = 1'b1;
  always #5 CLK = ~CLK;

  vid_ctl_gen_if bus ();

  vid_ctl_gen #(.HMAX(9'd340)) dut (.CLK(CLK), .RES(RES), .bus(bus));

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  logic [11:0] outs;
  assign outs = {bus.SYNC, bus.BURST, bus.n_PICTURE, bus.n_CC, bus.n_LL, bus.n_TR, bus.n_TG, bus.n_TB};

  localparam logic [11:0] IDLE      = 12'b0_0_1_1111_11_111;
  localparam logic [11:0] EXP_SYNC  = 12'b1_0_1_1111_11_111;
  localparam logic [11:0] EXP_BURST = 12'b0_1_1_1111_11_111;
  localparam logic [11:0] EXP_PIC2A = 12'b0_0_0_0101_01_111;
  localparam logic [11:0] EXP_BG21  = 12'b0_0_1_1110_01_111;

  // One pixel tick: inputs set and PCLK raised at a negedge, PCLK dropped at the next negedge
  task automatic px(input int h, input int v, input logic [5:0] pal, input logic [5:0] bg,
                    input logic [2:0] emph);
    @(negedge CLK);
    bus.H_in    = 9'(h);
    bus.V_in    = 9'(v);
    bus.PAL_in  = pal;
    bus.BG_in   = bg;
    bus.EMPH_in = emph;
    bus.PCLK    = 1'b1;
    @(negedge CLK);
    bus.PCLK    = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK) bus.PCLK = 1'b1;
      @(negedge CLK) bus.PCLK = 1'b0;
    end
    total_cnt++;
    if (outs !== IDLE) $display("FAIL reset_idle: outs=%h expected %h", outs, IDLE);
    else pass_cnt++;
    total_cnt++;
    if (bus.ODD !== 1'b0) $display("FAIL reset_odd: ODD=%b expected 0", bus.ODD);
    else pass_cnt++;

    @(negedge CLK) RES = 1'b0;
    px(10, 0, 6'h2A, 6'h00, 3'b101);
    total_cnt++;
    if (outs !== IDLE) $display("FAIL release_tick1: outs=%h expected %h", outs, IDLE);
    else pass_cnt++;
    total_cnt++;
    if (bus.ODD !== 1'b0) $display("FAIL first_frame_odd: ODD=%b expected 0", bus.ODD);
    else pass_cnt++;
    px(11, 0, 6'h2A, 6'h00, 3'b101);
    total_cnt++;
    if (outs !== 12'b0_0_0_0101_01_010)
      $display("FAIL release_tick2: outs=%h expected %h", outs, 12'b0_0_0_0101_01_010);
    else pass_cnt++;

    // Mid-line reset with a pixel already sitting in stage 1
    px(12, 0, 6'h2A, 6'h00, 3'b101);
    @(negedge CLK);
    bus.PCLK = 1'b1;
    #2 RES = 1'b1;
    #1;
    total_cnt++;
    if (outs !== IDLE) $display("FAIL midline_reset: outs=%h expected %h", outs, IDLE);
    else pass_cnt++;
    @(negedge CLK) bus.PCLK = 1'b0;
    @(negedge CLK) bus.PCLK = 1'b1;
    @(negedge CLK) bus.PCLK = 1'b0;
    RES = 1'b0;
    px(20, 0, 6'h2A, 6'h00, 3'b000);
    total_cnt++;
    if (outs !== IDLE) $display("FAIL rerelease_tick1: outs=%h expected %h", outs, IDLE);
    else pass_cnt++;
    px(21, 0, 6'h2A, 6'h00, 3'b000);
    total_cnt++;
    if (outs !== EXP_PIC2A) $display("FAIL rerelease_tick2: outs=%h expected %h", outs, EXP_PIC2A);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    px(10, 20, 6'h2A, 6'h00, 3'b101);
    total_cnt++;
    if (outs !== EXP_PIC2A) $display("FAIL latency_tick1: outs=%h expected %h", outs, EXP_PIC2A);
    else pass_cnt++;
    px(0, 20, 6'h00, 6'h00, 3'b000);
    total_cnt++;
    if (outs !== 12'b0_0_0_0101_01_010)
      $display("FAIL latency_tick2: outs=%h expected %h", outs, 12'b0_0_0_0101_01_010);
    else pass_cnt++;
  endtask

  task automatic test_windows();
    logic [11:0] exp;
    for (int h = 0; h <= 341; h++) begin
      px((h <= 340) ? h : 0, 100, 6'h2A, 6'h21, 3'b000);
      if (h >= 1) begin
        int hh = h - 1;
        if (hh >= 277 && hh <= 301)      exp = EXP_SYNC;
        else if (hh >= 306 && hh <= 320) exp = EXP_BURST;
        else if (hh <= 255)              exp = EXP_PIC2A;
        else                             exp = EXP_BG21;
        total_cnt++;
        if (outs !== exp) $display("FAIL hsweep h=%0d: outs=%h expected %h", hh, outs, exp);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_vertical();
    for (int h = 0; h <= 341; h++) begin
      px((h <= 340) ? h : 0, 245, 6'h2A, 6'h21, 3'b000);
      if (h >= 1) begin
        total_cnt++;
        if (outs !== EXP_SYNC) $display("FAIL vsync h=%0d: outs=%h expected %h", h - 1, outs, EXP_SYNC);
        else pass_cnt++;
      end
    end
    px(5, 240, 6'h2A, 6'h21, 3'b000);
    px(0, 240, 6'h2A, 6'h21, 3'b000);
    total_cnt++;
    if (outs !== EXP_BG21) $display("FAIL v240_border: outs=%h expected %h", outs, EXP_BG21);
    else pass_cnt++;
  endtask

  task automatic test_range();
    px(400, 100, 6'h2A, 6'h21, 3'b010);
    px(341, 100, 6'h2A, 6'h21, 3'b000);
    total_cnt++;
    if (outs !== 12'b0_0_1_0000_11_101)
      $display("FAIL h400_blank: outs=%h expected %h", outs, 12'b0_0_1_0000_11_101);
    else pass_cnt++;
    px(340, 100, 6'h2A, 6'h21, 3'b000);
    total_cnt++;
    if (outs !== 12'b0_0_1_0000_11_111)
      $display("FAIL h341_blank: outs=%h expected %h", outs, 12'b0_0_1_0000_11_111);
    else pass_cnt++;
    px(0, 100, 6'h2A, 6'h21, 3'b000);
    total_cnt++;
    if (outs !== EXP_BG21) $display("FAIL h340_border: outs=%h expected %h", outs, EXP_BG21);
    else pass_cnt++;
  endtask

  task automatic test_parity();
    px(0, 261, 6'h00, 6'h00, 3'b000);
    total_cnt++;
    if (bus.ODD !== 1'b0) $display("FAIL odd_before_wrap: ODD=%b expected 0", bus.ODD);
    else pass_cnt++;
    px(0, 0, 6'h00, 6'h00, 3'b000);
    total_cnt++;
    if (bus.ODD !== 1'b1) $display("FAIL odd_wrap1: ODD=%b expected 1", bus.ODD);
    else pass_cnt++;
    px(1, 0, 6'h00, 6'h00, 3'b000);
    total_cnt++;
    if (bus.ODD !== 1'b1) $display("FAIL odd_hold_v0: ODD=%b expected 1", bus.ODD);
    else pass_cnt++;
    px(0, 1, 6'h00, 6'h00, 3'b000);
    px(0, 261, 6'h00, 6'h00, 3'b000);
    px(0, 0, 6'h00, 6'h00, 3'b000);
    total_cnt++;
    if (bus.ODD !== 1'b0) $display("FAIL odd_wrap2: ODD=%b expected 0", bus.ODD);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    px(10, 20, 6'h2A, 6'h00, 3'b000);
    px(400, 20, 6'h3F, 6'h00, 3'b111);
    bus.H_in    = 9'd280;
    bus.V_in    = 9'd0;
    bus.PAL_in  = 6'h3F;
    bus.EMPH_in = 3'b111;
    repeat (20) @(negedge CLK);
    total_cnt++;
    if (outs !== EXP_PIC2A) $display("FAIL hold_outs: outs=%h expected %h", outs, EXP_PIC2A);
    else pass_cnt++;
    total_cnt++;
    if (bus.ODD !== 1'b0) $display("FAIL hold_odd: ODD=%b expected 0", bus.ODD);
    else pass_cnt++;
  endtask

`ifdef VID_GRAYSCALE_EN
  task automatic test_gray();
    bus.GRAY = 1'b1;
    px(10, 20, 6'h2A, 6'h00, 3'b000);
    px(0, 20, 6'h00, 6'h00, 3'b000);
    total_cnt++;
    if (outs !== 12'b0_0_0_1111_01_111)
      $display("FAIL gray_on: outs=%h expected %h", outs, 12'b0_0_0_1111_01_111);
    else pass_cnt++;
    bus.GRAY = 1'b0;
    px(10, 20, 6'h2A, 6'h00, 3'b000);
    px(0, 20, 6'h00, 6'h00, 3'b000);
    total_cnt++;
    if (outs !== EXP_PIC2A) $display("FAIL gray_off: outs=%h expected %h", outs, EXP_PIC2A);
    else pass_cnt++;
  endtask
`endif

  initial begin
    bus.PCLK    = 1'b0;
    bus.H_in    = '0;
    bus.V_in    = '0;
    bus.PAL_in  = '0;
    bus.BG_in   = '0;
    bus.EMPH_in = '0;
`ifdef VID_GRAYSCALE_EN
    bus.GRAY    = 1'b0;
`endif
    test_reset();
    test_latency();
    test_windows();
    test_vertical();
    test_range();
    test_parity();
    test_hold();
`ifdef VID_GRAYSCALE_EN
    test_gray();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
